// File: rtl/uart_tx_port_pkg.sv
// Shared state encoding, status-bit positions and default address window for
// the memory-mapped UART transmitter.
package uart_wires;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int unsigned STAT_BUSY  = 0;
  localparam int unsigned STAT_FULL  = 1;
  localparam int unsigned STAT_EMPTY = 2;

  localparam logic [31:0] UART_BASE_ADDR  = 32'h0010_0000;
  localparam logic [31:0] UART_TOP_ADDR   = 32'h0010_0004;
  localparam int unsigned UART_FIFO_DEPTH = 4;

endpackage

// File: rtl/uart_fifo.sv
// Small power-of-two FIFO with combinational head read, so the consumer can
// pop straight into its own register on the same edge.
module uart_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  always_ff @(posedge clock) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: bus writes queue bytes in a FIFO, reads
// return transmitter status, and an FSM serialises queued bytes onto uart_tx.
module uart_tx_port
  import uart_wires::*;
#(
  parameter int unsigned clks_per_bit = 868,
  parameter int unsigned fifo_depth   = UART_FIFO_DEPTH,
  parameter logic [31:0] base_addr    = UART_BASE_ADDR,
  parameter logic [31:0] top_addr     = UART_TOP_ADDR
) (
  input  logic        reset,
  input  logic        clock,
  input  logic        uart_valid,
  input  logic        uart_instr,
  input  logic [31:0] uart_addr,
  input  logic [31:0] uart_wdata,
  input  logic [3:0]  uart_wstrb,
  output logic [31:0] uart_rdata,
  output logic        uart_ready,
  output logic        uart_tx
);
  localparam int unsigned   CW       = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(clks_per_bit - 1);

  logic        ready_q;
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  uart_state_t   state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          tx_q;

  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;
  logic [7:0] fifo_head;

  logic in_window;
  logic is_read;
  logic wants_push;
  logic accept;
  logic baud_wrap;
  logic unused_wdata;

  assign in_window  = (uart_addr >= base_addr) && (uart_addr < top_addr);
  assign is_read    = uart_instr || (uart_wstrb == 4'b0000);
  assign wants_push = in_window && !is_read && uart_wstrb[0];
  // A byte write against a full FIFO is held off rather than dropped.
  assign accept     = uart_valid && !ready_q && !(wants_push && fifo_full);
  assign fifo_push  = accept && wants_push;
  assign baud_wrap  = (cnt_q == CNT_LAST);
  assign fifo_pop   = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && baud_wrap));
  assign unused_wdata = ^uart_wdata[31:8];

  always_comb begin
    rdata_d = '0;
    if (in_window && is_read) begin
      rdata_d[STAT_BUSY]  = (state_q != IDLE);
      rdata_d[STAT_FULL]  = fifo_full;
      rdata_d[STAT_EMPTY] = fifo_empty;
    end
  end

  uart_fifo #(
    .DEPTH (fifo_depth),
    .WIDTH (8)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (fifo_push),
    .data_i  (uart_wdata[7:0]),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= accept;
      rdata_q <= accept ? rdata_d : '0;
    end
  end

  // tx is registered from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shift_q[0];
        default: tx_q <= 1'b1;
      endcase
      case (state_q)
        IDLE: begin
          if (fifo_pop) begin
            shift_q <= fifo_head;
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_wrap) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            cnt_q   <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            idx_q   <= idx_q + 1'b1;
            if (idx_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_wrap) begin
            cnt_q <= '0;
            if (fifo_pop) begin
              shift_q <= fifo_head;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uart_ready = ready_q;
  assign uart_rdata = rdata_q;
  assign uart_tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port: bus writes feed a byte scoreboard that a
// serial-line monitor drains, plus handshake, status and reset checks.
module tb_uart_tx_port;
  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam logic [31:0] OUTW = 32'h0010_0008;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        instr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  strb = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        tx;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ready_cyc = 0;
  int frames_done = 0;
  int starts[$];
  logic [7:0] sb_q[$];

  bit         mon_busy = 1'b0;
  int         mon_off = 0;
  logic [7:0] rx = '0;

  uart_tx_port #(
    .clks_per_bit (4),
    .fifo_depth   (4)
  ) dut (
    .reset      (rst_n),
    .clock      (clk),
    .uart_valid (valid),
    .uart_instr (instr),
    .uart_addr  (addr),
    .uart_wdata (wdata),
    .uart_wstrb (strb),
    .uart_rdata (rdata),
    .uart_ready (ready),
    .uart_tx    (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Serial monitor: samples mid-bit on the falling clock edge (4 cycles per bit).
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (tx === 1'b0) begin
        mon_busy = 1'b1;
        mon_off  = 0;
        starts.push_back(cyc);
      end
    end else begin
      mon_off++;
      if (mon_off == 2) begin
        check("start_bit", {31'b0, tx}, 32'h0);
      end else if (mon_off >= 6 && mon_off <= 34 && (mon_off % 4) == 2) begin
        rx[(mon_off - 6) / 4] = tx;
      end else if (mon_off == 38) begin
        check("stop_bit", {31'b0, tx}, 32'h1);
        check("frame_expected", {31'b0, sb_q.size() != 0}, 32'h1);
        if (sb_q.size() != 0) check("frame_byte", {24'b0, rx}, {24'b0, sb_q.pop_front()});
        frames_done++;
      end else if (mon_off == 39) begin
        mon_busy = 1'b0;
      end
    end
  end

  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic ins, output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    valid = 1'b1; addr = a; wdata = d; strb = s; instr = ins;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ready && lat < 2000);
    check("ready_seen", {31'b0, ready}, 32'h1);
    ready_cyc = cyc;
    rd = rdata;
    valid = 1'b0; strb = '0; instr = 1'b0;
    @(posedge clk); #1;
    check("ready_pulse", {31'b0, ready}, 32'h0);
  endtask

  task automatic write_byte(input logic [31:0] a, input logic [7:0] b, output int lat);
    logic [31:0] rd;
    xfer(a, {24'hABCDEF, b}, 4'b0001, 1'b0, rd, lat);
    if (a >= BASE && a < BASE + 4) sb_q.push_back(b);
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (frames_done < n && k < 3000) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("frames_done", frames_done, n);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lat;
    int n0;
    int f0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'b0, tx}, 32'h1);
    check("rst_ready", {31'b0, ready}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_tx", {31'b0, tx}, 32'h1);
    check("post_rst_ready", {31'b0, ready}, 32'h0);
    xfer(BASE, 32'h0, 4'b0000, 1'b0, rd, lat);
    check("rst_status", rd, 32'h4);
    check("read_lat", lat, 1);

    // Single byte, start latency, and a status read while the frame is running.
    write_byte(BASE, 8'h55, lat);
    check("wr55_lat", lat, 1);
    n0 = ready_cyc;
    xfer(BASE, 32'h0, 4'b0000, 1'b0, rd, lat);
    check("busy_status", rd, 32'h5);
    wait_frames(1);
    check("start_count", starts.size(), 1);
    check("start_latency", starts[0] - n0, 2);

    // Back-to-back frames must abut exactly.
    n0 = starts.size();
    write_byte(BASE, 8'h41, lat);
    write_byte(BASE, 8'h42, lat);
    wait_frames(3);
    check("b2b_gap", starts[n0 + 1] - starts[n0], 40);
    repeat (10) @(posedge clk);

    // Fill shift register plus all four FIFO slots, then stall on one more.
    n0 = starts.size();
    for (int i = 0; i < 5; i++) begin
      write_byte(BASE, 8'h30 + 8'(i), lat);
      check($sformatf("fill_lat_%0d", i), lat, 1);
    end
    xfer(BASE, 32'h0, 4'b0000, 1'b0, rd, lat);
    check("full_status", rd, 32'h3);
    write_byte(BASE, 8'h35, lat);
    check("stall_lat_range", {31'b0, (lat >= 20) && (lat <= 45)}, 32'h1);
    wait_frames(9);
    for (int j = 0; j < 5; j++) check($sformatf("stall_gap_%0d", j), starts[n0 + j + 1] - starts[n0 + j], 40);
    repeat (10) @(posedge clk);

    // Out-of-window accesses and non-pushing writes complete without side effects.
    n0 = starts.size();
    f0 = frames_done;
    xfer(OUTW, 32'hAA, 4'b0001, 1'b0, rd, lat);
    check("oow_wr_lat", lat, 1);
    check("oow_wr_rdata", rd, 32'h0);
    xfer(OUTW, 32'h0, 4'b0000, 1'b0, rd, lat);
    check("oow_rd_rdata", rd, 32'h0);
    xfer(BASE, 32'hBB, 4'b0010, 1'b0, rd, lat);
    check("nostrb0_lat", lat, 1);
    xfer(BASE, 32'h0, 4'b0001, 1'b1, rd, lat);
    check("instr_status", rd, 32'h4);
    repeat (60) @(posedge clk);
    #1;
    check("no_new_start", starts.size(), n0);
    check("no_new_frame", frames_done, f0);

    // Reset during data bit 3 of 0x00 (line low) must force the line high at once.
    write_byte(BASE, 8'h00, lat);
    repeat (19) @(posedge clk);
    #1;
    check("bit3_low", {31'b0, tx}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("reset_tx_high", {31'b0, tx}, 32'h1);
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = starts.size();
    f0 = frames_done;
    xfer(BASE, 32'h0, 4'b0000, 1'b0, rd, lat);
    check("post_abort_status", rd, 32'h4);
    repeat (80) @(posedge clk);
    #1;
    check("no_residual_frame", starts.size(), n0);
    check("idle_tx", {31'b0, tx}, 32'h1);
    write_byte(BASE, 8'hC3, lat);
    wait_frames(f0 + 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
